ifm_chunk_sparse_writer: RTL and testbench

- Producer end of the IFM data-chunk write interface.
- Accepts dense 8-bit IFM activation beats through a valid/ready handshake.
- Per beat, generates the sparsemap and the left-compacted nonzero bytes, then drives the double-buffered chunk store's write port: sparsemap, nonzero data, valid, beat count and bank select.
- Tracks ownership of both chunk banks, so a bank is never overwritten before the compute side releases it.

---
 rtl/ifm_wr_pkg.sv | 12 +
 rtl/ifm_chunk_sparse_writer_compactor.sv | 27 ++
 rtl/ifm_chunk_sparse_writer.sv | 96 +++++++++
 tb/tb_ifm_chunk_sparse_writer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ifm_wr_pkg.sv
// ifm_wr_pkg: shared byte/beat/count types for the IFM chunk write path.
`ifndef BUS_SIZE
`define BUS_SIZE 8
`endif
`ifndef WR_DAT_CYC_NUM
`define WR_DAT_CYC_NUM 4
`endif
package ifm_wr_pkg;
   typedef logic [7:0] byte_t;
   typedef byte_t [`BUS_SIZE-1:0] beat_t;
   typedef logic [$clog2(`WR_DAT_CYC_NUM)-1:0] wr_cnt_t;
endpackage

// File: rtl/ifm_chunk_sparse_writer_compactor.sv
// Beat_Compactor: sparsemap, left-compacted nonzero bytes and popcount of one dense beat.
module Beat_Compactor
   import ifm_wr_pkg::*;
#(
   parameter int BUS_SIZE = 8
) (
   input  logic [BUS_SIZE*8-1:0]      dense_i,
   output logic [BUS_SIZE-1:0]        sparsemap_o,
   output logic [BUS_SIZE*8-1:0]      data_o,
   output logic [$clog2(BUS_SIZE):0]  nz_cnt_o
);
   byte_t [BUS_SIZE-1:0]     comp;
   logic [$clog2(BUS_SIZE):0] pos;
   // pos is the exclusive prefix sum of the sparsemap, i.e. the scatter slot of byte i
   always_comb begin
      comp = '0;
      pos = '0;
      sparsemap_o = '0;
      for (int i = 0; i < BUS_SIZE; i++) begin
         sparsemap_o[i] = |dense_i[i*8 +: 8];
         if (sparsemap_o[i]) comp[pos[$clog2(BUS_SIZE)-1:0]] = dense_i[i*8 +: 8];
         pos = pos + {{$clog2(BUS_SIZE){1'b0}}, sparsemap_o[i]};
      end
   end
   assign data_o = comp;
   assign nz_cnt_o = pos;
endmodule

// File: rtl/ifm_chunk_sparse_writer.sv
// ifm_chunk_sparse_writer: compacts dense IFM beats and writes them into a
// double-buffered chunk store, tracking which bank each side owns.
`ifndef BUS_SIZE
`define BUS_SIZE 8
`endif
`ifndef WR_DAT_CYC_NUM
`define WR_DAT_CYC_NUM 4
`endif
module ifm_chunk_sparse_writer
   import ifm_wr_pkg::*;
#(
   parameter int BUS_SIZE       = `BUS_SIZE,
   parameter int WR_DAT_CYC_NUM = `WR_DAT_CYC_NUM
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [BUS_SIZE*8-1:0]             dense_data_i,
   input  logic                              dense_valid_i,
   output logic                              dense_ready_o,
   output logic [BUS_SIZE-1:0]               wr_sparsemap_o,
   output logic [BUS_SIZE*8-1:0]             wr_nonzero_data_o,
   output logic [$clog2(BUS_SIZE):0]         wr_nz_cnt_o,
   output logic                              wr_valid_o,
   output logic [$clog2(WR_DAT_CYC_NUM)-1:0] wr_count_o,
   output logic                              wr_sel_o,
   output logic                              rd_sel_o,
   output logic                              rd_valid_o,
   input  logic                              rd_release_i
);
   localparam int CW = $clog2(WR_DAT_CYC_NUM);
   localparam int NW = $clog2(BUS_SIZE) + 1;
   logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]            full_q, full_d;
   logic [CW-1:0]         beat_cnt_q, beat_cnt_d;
   logic                  wr_valid_q, wr_sel_q;
   logic [CW-1:0]         wr_count_q;
   logic [BUS_SIZE-1:0]   sm_q, sm_c;
   logic [BUS_SIZE*8-1:0] data_q, data_c;
   logic [NW-1:0]         nz_q, nz_c;
   logic                  acc, last, rel;
   Beat_Compactor #(.BUS_SIZE(BUS_SIZE)) u_compactor (
      .dense_i     (dense_data_i),
      .sparsemap_o (sm_c),
      .data_o      (data_c),
      .nz_cnt_o    (nz_c)
   );
   assign dense_ready_o = !full_q[wr_ptr_q];
   assign acc  = dense_valid_i && dense_ready_o;
   assign last = beat_cnt_q == CW'(WR_DAT_CYC_NUM - 1);
   assign rel  = rd_release_i && full_q[rd_ptr_q];
   // the write bank is always empty and the read bank full, so both updates can apply together
   always_comb begin
      beat_cnt_d = acc ? (last ? '0 : beat_cnt_q + CW'(1)) : beat_cnt_q;
      wr_ptr_d = wr_ptr_q ^ (acc && last);
      rd_ptr_d = rd_ptr_q ^ rel;
      full_d = full_q;
      if (acc && last) full_d[wr_ptr_q] = 1'b1;
      if (rel) full_d[rd_ptr_q] = 1'b0;
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         full_q     <= '0;
         beat_cnt_q <= '0;
         wr_valid_q <= 1'b0;
         wr_sel_q   <= 1'b0;
         wr_count_q <= '0;
         sm_q       <= '0;
         data_q     <= '0;
         nz_q       <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         full_q     <= full_d;
         beat_cnt_q <= beat_cnt_d;
         wr_valid_q <= acc;
         if (acc) begin
            wr_sel_q   <= wr_ptr_q;
            wr_count_q <= beat_cnt_q;
            sm_q       <= sm_c;
            data_q     <= data_c;
            nz_q       <= nz_c;
         end
      end
   end
   assign wr_valid_o        = wr_valid_q;
   assign wr_sel_o          = wr_sel_q;
   assign wr_count_o        = wr_count_q;
   assign wr_sparsemap_o    = sm_q;
   assign wr_nonzero_data_o = data_q;
   assign wr_nz_cnt_o       = nz_q;
   assign rd_sel_o          = rd_ptr_q;
   // a just-completed chunk stays hidden while its last beat is still on the write port
   assign rd_valid_o        = full_q[rd_ptr_q] && !(wr_valid_q && wr_sel_q == rd_ptr_q);
endmodule

// File: tb/tb_ifm_chunk_sparse_writer.sv
// tb_ifm_chunk_sparse_writer: directed plus random beats checked against a
// chunk-queue reference model of the writer.
module tb_ifm_chunk_sparse_writer;
   localparam int BS = 8;
   localparam int WN = 4;
   logic          clk = 1'b0;
   logic          rst_i = 1'b0;
   logic [63:0]   dense = '0;
   logic          dv = 1'b0, rel = 1'b0;
   logic          ready, wv, ws, rs, rv;
   logic [7:0]    sm;
   logic [63:0]   nzd;
   logic [3:0]    nzc;
   logic [1:0]    wc;
   int errs = 0, checks = 0;
   int beats, released, chunks[$];
   bit just_done, e_wv, e_ws;
   int e_wc, e_k;
   logic [7:0]  e_sm;
   logic [63:0] e_data;

   ifm_chunk_sparse_writer #(.BUS_SIZE(BS), .WR_DAT_CYC_NUM(WN)) dut (
      .clk_i(clk), .rst_i(rst_i), .dense_data_i(dense), .dense_valid_i(dv),
      .dense_ready_o(ready), .wr_sparsemap_o(sm), .wr_nonzero_data_o(nzd),
      .wr_nz_cnt_o(nzc), .wr_valid_o(wv), .wr_count_o(wc), .wr_sel_o(ws),
      .rd_sel_o(rs), .rd_valid_o(rv), .rd_release_i(rel)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] compact(input logic [63:0] d, output logic [7:0] m, output int k);
      logic [63:0] r = '0;
      m = '0;
      k = 0;
      for (int i = 0; i < BS; i++)
         if (d[i*8 +: 8] != 8'h00) begin
            m[i] = 1'b1;
            r[k*8 +: 8] = d[i*8 +: 8];
            k++;
         end
      return r;
   endfunction

   task automatic model_reset();
      beats = 0; released = 0; chunks.delete(); just_done = 0;
      e_wv = 0; e_ws = 0; e_wc = 0; e_k = 0; e_sm = '0; e_data = '0;
   endtask

   task automatic check_all();
      bit ev;
      ev = chunks.size() > 0 && !(just_done && chunks.size() == 1);
      check("ready", ready, chunks.size() < 2);
      check("rd_valid", rv, ev);
      check("rd_sel", rs, chunks.size() > 0 ? chunks[0] : released % 2);
      check("wr_valid", wv, e_wv);
      check("wr_sel", ws, e_ws);
      check("wr_count", wc, e_wc);
      check("sparsemap", sm, e_sm);
      check("nz_data", nzd, e_data);
      check("nz_cnt", nzc, e_k);
   endtask

   // called at a falling edge; returns at the next falling edge
   task automatic cycle(input logic v, input logic [63:0] d, input logic r);
      bit acc;
      check_all();
      dv = v; dense = d; rel = r;
      acc = v && chunks.size() < 2;
      if (r && chunks.size() > 0) begin
         void'(chunks.pop_front());
         released++;
      end
      just_done = 0;
      e_wv = acc;
      if (acc) begin
         e_wc = beats % WN;
         e_ws = (beats / WN) % 2;
         beats++;
         e_data = compact(d, e_sm, e_k);
         if (e_wc == WN - 1) begin
            chunks.push_back(e_ws);
            just_done = 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [63:0] rnd_beat();
      logic [63:0] r;
      for (int i = 0; i < BS; i++) r[i*8 +: 8] = ($urandom % 2) ? 8'($urandom) : 8'h00;
      return r;
   endfunction

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst_i = 1'b1;
      cycle(1, 64'h0005000009000003, 0);
      check("t1_sm", sm, 8'h49);
      check("t1_data", nzd, 64'h0000000000050903);
      check("t1_cnt", nzc, 4'd3);
      for (int i = 0; i < 3; i++) cycle(1, rnd_beat(), 0);
      check("t2_count3", wc, 2'd3);
      check("t2_rv_hidden", rv, 1'b0);
      cycle(1, rnd_beat(), 0);
      check("t2_rv", rv, 1'b1);
      check("t2_rs", rs, 1'b0);
      check("t2_sel5", ws, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1, rnd_beat(), 0);
      for (int i = 0; i < 3; i++) cycle(1, rnd_beat(), 0);
      check("t3_stall", ready, 1'b0);
      cycle(0, '0, 1);
      check("t3_ready", ready, 1'b1);
      check("t3_rs", rs, 1'b1);
      check("t3_rv", rv, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1, rnd_beat(), 0);
      cycle(1, rnd_beat(), 1);
      check("t4_rs", rs, 1'b0);
      cycle(1, 64'h0, 0);
      check("t4_rv", rv, 1'b1);
      cycle(0, '0, 1);
      cycle(1, 64'h0, 0);
      check("t5_zero_sm", sm, 8'h00);
      check("t5_zero_cnt", nzc, 4'd0);
      cycle(1, 64'h0807060504030201, 0);
      check("t5_full_sm", sm, 8'hFF);
      check("t5_full_cnt", nzc, 4'd8);
      check("t5_full_data", nzd, 64'h0807060504030201);
      cycle(0, '0, 1);
      cycle(0, '0, 1);
      cycle(1, rnd_beat(), 0);
      cycle(1, rnd_beat(), 0);
      rst_i = 1'b0;
      dv = 1'b0; rel = 1'b0;
      #1;
      model_reset();
      check("t6_wv", wv, 1'b0);
      check("t6_data", nzd, 64'h0);
      check("t6_rv", rv, 1'b0);
      @(negedge clk);
      check_all();
      rst_i = 1'b1;
      cycle(0, '0, 1);
      cycle(1, rnd_beat(), 0);
      check("t6_count", wc, 2'd0);
      check("t6_sel", ws, 1'b0);
      for (int i = 0; i < 400; i++)
         cycle(($urandom % 10) < 7, rnd_beat(), ($urandom % 10) < 3);
      check_all();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
